pu_ram_arbiter: RTL and testbench

- Shares the single-port PPU RAM between two requesters: the video scanout fetcher (read-only, latency-critical) and the PPU core (CPU16, read/write).
- Sits between both requesters and the PPU RAM ports (addr/din/we/dout), replacing the direct PPU-to-RAM wiring.
- Video has fixed priority. A starvation counter guarantees the PPU forward progress, and a lock mode gives the PPU short atomic bursts.

---
 rtl/pu_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_pu_ram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// pu_ram_arbiter
//
// Shares the single-port PPU RAM between the video scanout fetcher (read-only,
// latency-critical) and the PPU core (read/write). Video has fixed priority;
// a starvation counter guarantees the PPU eventually wins, and a lock mode
// lets the PPU keep the RAM for a short burst of consecutive grants.
//
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   vid_req/vid_addr  video read request (held until granted) and address
//   vid_gnt           video owns the RAM this cycle
//   vid_rvalid/rdata  video read data, one cycle after a granted read
//   ppu_req/addr/wdata/we/lock
//                     PPU request (held until granted), 1 = write, lock
//                     asks to keep the grant on following cycles
//   ppu_gnt           PPU owns the RAM this cycle
//   ppu_rvalid/rdata  PPU read data, one cycle after a granted read
//   ram_addr/din/we   RAM drive, ram_dout RAM read data (valid next cycle)
//   dbg_state         current arbiter state (0 = ARB, 1 = LOCK)
//
// Handshake: a requester raises req with its address/data and holds them
// unchanged until it sees gnt = 1 in the same cycle; the access happens in
// that cycle. A granted read returns rvalid = 1 with rdata exactly one cycle
// later; rdata is meaningless whenever rvalid = 0. Writes return nothing.
// ---------------------------------------------------------------------------
module pu_ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_LOCK     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [DATA_W-1:0] ppu_wdata,
  input  logic              ppu_we,
  input  logic              ppu_lock,
  output logic              ppu_gnt,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              dbg_state
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int LC_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [LC_W-1:0]   r_lock_cnt;
  logic [LC_W-1:0]   w_lock_nxt;
  logic              r_vid_rvalid;
  logic              r_ppu_rvalid;
  logic              w_vid_gnt;
  logic              w_ppu_gnt;
  logic              w_starved;
  logic              w_lock_hold;

  // PPU has waited long enough: it beats a pending video request once.
  assign w_starved   = ppu_req && (r_starve_cnt == SC_W'(STARVE_LIMIT));

  // Locked burst continues only while the PPU keeps asking and the burst
  // has not yet reached its maximum length.
  assign w_lock_hold = (r_state == ST_LOCK) && ppu_req && ppu_lock &&
                       (r_lock_cnt < LC_W'(MAX_LOCK));

  always_comb begin
    w_vid_gnt   = 1'b0;
    w_ppu_gnt   = 1'b0;
    w_state_nxt = ST_ARB;
    w_lock_nxt  = '0;
    // No grants at all while reset is asserted.
    if (reset) begin
      if (w_lock_hold) begin
        w_ppu_gnt   = 1'b1;
        w_state_nxt = ST_LOCK;
        w_lock_nxt  = r_lock_cnt + LC_W'(1);
      end else begin
        if (w_starved) begin
          w_ppu_gnt = 1'b1;
        end else if (vid_req) begin
          w_vid_gnt = 1'b1;
        end else if (ppu_req) begin
          w_ppu_gnt = 1'b1;
        end
        // A lock can only be opened from ARB; the cycle that ends a lock
        // (forced or voluntary) always falls back to ARB first.
        if ((r_state == ST_ARB) && w_ppu_gnt && ppu_lock) begin
          w_state_nxt = ST_LOCK;
          w_lock_nxt  = LC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_ARB;
      r_lock_cnt   <= '0;
      r_starve_cnt <= '0;
      r_vid_rvalid <= 1'b0;
      r_ppu_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
      if (w_ppu_gnt) begin
        r_starve_cnt <= '0;
      end else if (ppu_req && (r_starve_cnt != SC_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
      r_vid_rvalid <= w_vid_gnt;
      r_ppu_rvalid <= w_ppu_gnt && !ppu_we;
    end
  end

  assign vid_gnt    = w_vid_gnt;
  assign ppu_gnt    = w_ppu_gnt;
  assign vid_rvalid = r_vid_rvalid;
  assign ppu_rvalid = r_ppu_rvalid;
  assign vid_rdata  = ram_dout;
  assign ppu_rdata  = ram_dout;

  assign ram_addr = w_vid_gnt ? vid_addr : (w_ppu_gnt ? ppu_addr : '0);
  assign ram_din  = w_ppu_gnt ? ppu_wdata : '0;
  assign ram_we   = w_ppu_gnt && ppu_we;

  assign dbg_state = r_state;

endmodule

// File: tb/tb_pu_ram_arbiter.sv
module tb_pu_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SL = 8;
  localparam int ML = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          vid_req, vid_gnt, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          ppu_req, ppu_we, ppu_lock, ppu_gnt, ppu_rvalid;
  logic [AW-1:0] ppu_addr;
  logic [DW-1:0] ppu_wdata, ppu_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;
  logic          dbg_state;

  pu_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .ppu_we(ppu_we), .ppu_lock(ppu_lock), .ppu_gnt(ppu_gnt),
    .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // ---------------- RAM model (synchronous read) ----------------
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a};
  endfunction

  logic [DW-1:0] mem [0:255];
  logic          mem_written [0:255] = '{default: 1'b0};

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[7:0]]         <= ram_din;
      mem_written[ram_addr[7:0]] <= 1'b1;
    end
    ram_dout <= mem_written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : init_val(ram_addr[7:0]);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t vid_exp_q[$];
  exp_t ppu_exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit m_known  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (spec rules, plain integers) --------------
  logic [DW-1:0] ref_mem [0:255];
  int m_wait = 0;   // consecutive cycles the PPU has asked and been refused
  int m_run  = 0;   // length of current locked burst, 0 when not locked

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (m_known) begin
      if (vid_rvalid) begin
        if (vid_exp_q.size() == 0) begin
          check("vid_rvalid_spurious", 32'(vid_rvalid), 32'd0);
        end else begin
          e = vid_exp_q.pop_front();
          check("vid_rvalid_cycle", 32'(cyc), 32'(e.due));
          check("vid_rdata", 32'(vid_rdata), 32'(e.data));
        end
      end else if (vid_exp_q.size() > 0 && vid_exp_q[0].due <= cyc) begin
        e = vid_exp_q.pop_front();
        check("vid_rvalid_missing", 32'(vid_rvalid), 32'd1);
      end
      if (ppu_rvalid) begin
        if (ppu_exp_q.size() == 0) begin
          check("ppu_rvalid_spurious", 32'(ppu_rvalid), 32'd0);
        end else begin
          e = ppu_exp_q.pop_front();
          check("ppu_rvalid_cycle", 32'(cyc), 32'(e.due));
          check("ppu_rdata", 32'(ppu_rdata), 32'(e.data));
        end
      end else if (ppu_exp_q.size() > 0 && ppu_exp_q[0].due <= cyc) begin
        e = ppu_exp_q.pop_front();
        check("ppu_rvalid_missing", 32'(ppu_rvalid), 32'd1);
      end
    end
  end

  // ---------------- driver: one bus cycle ----------------
  task automatic do_cycle(input bit rst_n, input bit vr, input logic [AW-1:0] va,
                          input bit pr, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                          input bit pw, input bit pl, output bit gv, output bit gp);
    bit            locked;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    reset = rst_n; vid_req = vr; vid_addr = va;
    ppu_req = pr; ppu_addr = pa; ppu_wdata = pd; ppu_we = pw; ppu_lock = pl;
    #1;
    gv = 1'b0; gp = 1'b0;
    locked = (m_run > 0);
    if (m_known) check("dbg_state", 32'(dbg_state), 32'(locked));
    if (rst_n) begin
      if (locked && pr && pl && m_run < ML) begin
        gp = 1'b1;
        m_run++;
      end else begin
        if (pr && m_wait == SL) gp = 1'b1;
        else if (vr)            gv = 1'b1;
        else if (pr)            gp = 1'b1;
        m_run = (!locked && gp && pl) ? 1 : 0;
      end
      if (gp)                     m_wait = 0;
      else if (pr && m_wait < SL) m_wait++;
    end else begin
      m_wait = 0;
      m_run  = 0;
    end
    exp_addr = gv ? va : (gp ? pa : '0);
    check("vid_gnt", 32'(vid_gnt), 32'(gv));
    check("ppu_gnt", 32'(ppu_gnt), 32'(gp));
    check("ram_we", 32'(ram_we), 32'(gp && pw));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    if (gp && pw) check("ram_din", 32'(ram_din), 32'(pd));
    if (gv) vid_exp_q.push_back('{due: cyc + 1, data: ref_mem[va[7:0]]});
    if (gp && !pw) ppu_exp_q.push_back('{due: cyc + 1, data: ref_mem[pa[7:0]]});
    if (gp && pw) ref_mem[pa[7:0]] = pd;
    if (!rst_n) m_known = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit gv, gp;
    bit vr, pr, pw, pl, rn;
    logic [AW-1:0] va, pa;
    logic [DW-1:0] pd;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    reset = 1'b0; vid_req = 1'b0; vid_addr = '0; ppu_req = 1'b0; ppu_addr = '0;
    ppu_wdata = '0; ppu_we = 1'b0; ppu_lock = 1'b0;

    // Reset held with both requests high: nothing granted.
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 16'h0010, 1, 16'h0030, 16'h0, 0, 0, gv, gp);

    // First cycle after release: video wins, reads 0xBEEF.
    do_cycle(1, 1, 16'h0010, 1, 16'h0030, 16'h0, 0, 0, gv, gp);
    check("post_reset_vid_first", 32'(vid_gnt), 32'd1);
    do_cycle(1, 0, 16'h0000, 1, 16'h0030, 16'h0, 0, 0, gv, gp);

    // PPU write then read back.
    do_cycle(1, 0, 16'h0000, 1, 16'h0020, 16'h1234, 1, 0, gv, gp);
    check("ppu_write_we", 32'(ram_we), 32'd1);
    do_cycle(1, 0, 16'h0000, 1, 16'h0020, 16'h0000, 0, 0, gv, gp);
    do_cycle(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, gv, gp);

    // Starvation: both held; PPU every 9th cycle.
    for (int i = 0; i < 27; i++) begin
      do_cycle(1, 1, 16'(8'(i)), 1, 16'h0020, 16'h0, 0, 0, gv, gp);
      check("starve_pattern", 32'(ppu_gnt), 32'(i % 9 == 8));
    end

    // Lock burst: video arrives on 2nd cycle, wins the 5th, PPU relocks 6th.
    for (int i = 0; i < 6; i++) begin
      do_cycle(1, (i >= 1 && i <= 4), 16'h0011, 1, 16'h0040 + 16'(i), 16'h0, 0, 1, gv, gp);
      check("lock_pattern_ppu", 32'(ppu_gnt), 32'(i != 4));
    end
    do_cycle(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, gv, gp);

    // Reset in the middle of a lock (lock_cnt = 2).
    do_cycle(1, 0, 16'h0012, 1, 16'h0005, 16'h0, 0, 1, gv, gp);
    do_cycle(1, 1, 16'h0012, 1, 16'h0006, 16'h0, 0, 1, gv, gp);
    do_cycle(0, 1, 16'h0012, 1, 16'h0007, 16'h0, 0, 1, gv, gp);
    do_cycle(1, 1, 16'h0012, 1, 16'h0007, 16'h0, 0, 1, gv, gp);
    check("midlock_state_arb", 32'(dbg_state), 32'd0);
    check("midlock_vid_first", 32'(vid_gnt), 32'd1);
    do_cycle(1, 0, 16'h0, 1, 16'h0007, 16'h0, 0, 1, gv, gp);
    do_cycle(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, gv, gp);

    // Randomized traffic with occasional resets.
    vr = 0; pr = 0; va = '0; pa = '0; pd = '0; pw = 0; pl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!vr && $urandom_range(0, 99) < 40) begin
        vr = 1; va = 16'($urandom_range(0, 31));
      end
      if (!pr && $urandom_range(0, 99) < 55) begin
        pr = 1; pa = 16'($urandom_range(0, 31)); pd = 16'($urandom);
        pw = ($urandom_range(0, 2) == 0); pl = ($urandom_range(0, 2) == 0);
      end
      rn = ($urandom_range(0, 299) != 0);
      do_cycle(rn, vr, va, pr, pa, pd, pw, pl, gv, gp);
      if (gv) vr = 0;
      if (gp) pr = 0;
    end

    do_cycle(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, gv, gp);
    do_cycle(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, gv, gp);
    check("vid_queue_drained", 32'(vid_exp_q.size()), 32'd0);
    check("ppu_queue_drained", 32'(ppu_exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
